// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit for the execute stage
//
// Takes a decoded memory instruction (memwrite/memtoreg/memsize plus the ALU
// effective address, rs2 store data and rd), performs a single valid/ready
// transaction on the data-memory port and holds the pipeline with `stall`
// until the access has finished. Loads come back sign- or zero-extended and
// tagged with their destination register. Misaligned accesses and illegal
// size encodings never reach memory; they produce a one-cycle lsu_err.
//
// Ports
//   clk, rst_n             clock (rising edge) and async active-low reset
//   req_valid              EX stage holds a decoded instruction
//   memwrite, memtoreg     store / load request
//   memsize[2:0]           funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr[ADDR_W-1:0]       effective byte address
//   wdata[31:0]            store data (rs2)
//   rd[4:0]                load destination register
//   stall                  freeze PC/IF/ID/EX
//   mem_req, mem_we        memory request valid / write enable
//   mem_addr               word-aligned address
//   mem_be[3:0]            byte enables
//   mem_wdata[31:0]        store data replicated into the byte lanes
//   mem_ready              memory accepts the request
//   mem_rvalid, mem_rdata  read data return
//   wb_valid, wb_rd,
//   wb_data                one-cycle load writeback
//   lsu_err                one-cycle misaligned/illegal pulse
// -----------------------------------------------------------------------------
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    input  logic              memwrite,
    input  logic              memtoreg,
    input  logic [2:0]        memsize,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd,

    output logic              stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,

    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              lsu_err
);

    // funct3 size encodings
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;

    // Operation context captured on acceptance
    logic              is_load_reg;
    logic [1:0]        offset_reg;
    logic [2:0]        size_reg;
    logic [4:0]        rd_reg;

    // Registered outputs
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_be_reg;
    logic [31:0]       mem_wdata_reg;
    logic              wb_valid_reg;
    logic [4:0]        wb_rd_reg;
    logic [31:0]       wb_data_reg;
    logic              lsu_err_reg;

    // -------------------------------------------------------------------------
    // Request decode (combinational, from the EX-stage inputs)
    // -------------------------------------------------------------------------
    logic        accept;
    logic [1:0]  offset;
    logic        size_legal;
    logic        aligned;
    logic        req_ok;

    assign offset = addr[1:0];

    // Only IDLE may accept; in DONE the instruction on the inputs is the one
    // that just completed, so it must not be started a second time.
    assign accept = (state_reg == IDLE) && req_valid && (memwrite || memtoreg);

    // Stores accept only the signed encodings B/H/W; loads additionally BU/HU.
    // memwrite takes precedence if both controls are set.
    always_comb begin
        size_legal = 1'b0;
        case (memsize)
            SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
            SZ_BU, SZ_HU:     size_legal = !memwrite;
            default:          size_legal = 1'b0;
        endcase
    end

    // Halfwords need an even address, words a multiple of four
    always_comb begin
        aligned = 1'b1;
        case (memsize[1:0])
            2'b01:   aligned = !offset[0];
            2'b10:   aligned = (offset == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign req_ok = size_legal && aligned;

    // -------------------------------------------------------------------------
    // Byte-lane steering for the request: one generate slice per lane.
    // memsize[1:0] selects B/H/W for both signed and unsigned loads.
    // -------------------------------------------------------------------------
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);

        // Byte: only the addressed lane; half: the addressed half; word: all
        assign be_next[gi] = (memsize[1:0] == 2'b00) ? (offset == LANE)       :
                             (memsize[1:0] == 2'b01) ? (offset[1] == LANE[1]) :
                                                       1'b1;

        // Store data is replicated so every enabled lane sees the right bytes
        assign wdata_next[8*gi +: 8] =
                             (memsize[1:0] == 2'b00) ? wdata[7:0]             :
                             (memsize[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8]   :
                                                       wdata[8*gi +: 8];
    end

    // -------------------------------------------------------------------------
    // Load data extraction, using the context latched at acceptance
    // -------------------------------------------------------------------------
    logic [31:0] lane_data;
    logic [31:0] load_ext;

    assign lane_data = mem_rdata >> {offset_reg, 3'b000};

    always_comb begin
        load_ext = lane_data;
        case (size_reg)
            SZ_B:    load_ext = {{24{lane_data[7]}},  lane_data[7:0]};
            SZ_H:    load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            SZ_BU:   load_ext = {24'd0, lane_data[7:0]};
            SZ_HU:   load_ext = {16'd0, lane_data[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Stall: combinational on acceptance so the pipeline freezes in the same
    // cycle the op is seen, then held through REQ and WAIT. Gated by rst_n so
    // the output is quiet while reset is asserted.
    // -------------------------------------------------------------------------
    assign stall = rst_n && (accept || (state_reg == REQ) || (state_reg == WAIT));

    // -------------------------------------------------------------------------
    // Control FSM with registered memory and writeback outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            is_load_reg   <= 1'b0;
            offset_reg    <= 2'b00;
            size_reg      <= 3'b000;
            rd_reg        <= 5'd0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= 32'd0;
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= 5'd0;
            wb_data_reg   <= 32'd0;
            lsu_err_reg   <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses
            wb_valid_reg <= 1'b0;
            lsu_err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_load_reg <= !memwrite;
                        offset_reg  <= offset;
                        size_reg    <= memsize;
                        rd_reg      <= rd;
                        if (req_ok) begin
                            state_reg     <= REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= memwrite;
                            mem_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be_reg    <= be_next;
                            mem_wdata_reg <= memwrite ? wdata_next : 32'd0;
                        end else begin
                            // Rejected without touching memory
                            state_reg   <= DONE;
                            lsu_err_reg <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    // Address/controls stay frozen until the handshake
                    if (mem_ready) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= is_load_reg ? WAIT : DONE;
                    end
                end

                WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= rd_reg;
                        wb_data_reg  <= load_ext;
                        state_reg    <= DONE;
                    end
                end

                DONE: begin
                    // One-cycle release so the pipeline advances past the op
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;
    assign lsu_err   = lsu_err_reg;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- directed, table-driven bench for lsu plus hand-written sequences
// for reset-during-WAIT and back-to-back store/load.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, memwrite, memtoreg;
    logic [2:0]  memsize;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .memwrite(memwrite), .memtoreg(memtoreg),
        .memsize(memsize), .addr(addr), .wdata(wdata), .rd(rd),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_err(lsu_err)
    );

    typedef struct {
        logic        we;
        logic        ld;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          rdy_wait;
        int          rv_wait;
        logic        err;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic we, input logic ld, input logic [2:0] size,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input logic [4:0] r, input int rw, input int vw, input logic err,
                                input logic [3:0] be, input logic [31:0] ma, input logic [31:0] mw,
                                input logic [31:0] wb);
        vec_t v;
        v.we = we; v.ld = ld; v.size = size; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.rd = r; v.rdy_wait = rw; v.rv_wait = vw; v.err = err; v.be = be;
        v.maddr = ma; v.mwdata = mw; v.wb = wb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},  {31'd0, stall},    32'd0);
        chk({tag, "_req"},    {31'd0, mem_req},  32'd0);
        chk({tag, "_we"},     {31'd0, mem_we},   32'd0);
        chk({tag, "_addr"},   mem_addr,          32'd0);
        chk({tag, "_be"},     {28'd0, mem_be},   32'd0);
        chk({tag, "_wdata"},  mem_wdata,         32'd0);
        chk({tag, "_wbv"},    {31'd0, wb_valid}, 32'd0);
        chk({tag, "_wbrd"},   {27'd0, wb_rd},    32'd0);
        chk({tag, "_wbdata"}, wb_data,           32'd0);
        chk({tag, "_err"},    {31'd0, lsu_err},  32'd0);
    endtask

    // Drive one op for a single cycle, then play the memory side on a fixed
    // schedule and check every cycle up to one past DONE.
    task automatic run_op(input vec_t v, input int idx);
        int   done_k;
        logic is_ld, exp_req, rd_cyc;
        is_ld = v.ld && !v.we;
        if (v.err)      done_k = 1;
        else if (is_ld) done_k = 3 + v.rdy_wait + v.rv_wait;
        else            done_k = 2 + v.rdy_wait;

        @(posedge clk); #1;
        req_valid = 1'b1; memwrite = v.we; memtoreg = v.ld; memsize = v.size;
        addr = v.addr; wdata = v.wdata; rd = v.rd;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = ~v.rdata;
        @(negedge clk);
        chk("stall_accept", {31'd0, stall}, 32'd1);

        for (int k = 1; k <= done_k + 1; k++) begin
            @(posedge clk); #1;
            // Scramble EX inputs: the op must run from latched context
            req_valid = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; memsize = 3'b111;
            addr = 32'hFFFF_FFFF; wdata = 32'h0; rd = 5'd0;
            exp_req = !v.err && (k <= 1 + v.rdy_wait);
            rd_cyc  = is_ld && !v.err && (k == 2 + v.rdy_wait + v.rv_wait);
            // ready only on the handshake cycle; also waved during WAIT where it must be ignored
            mem_ready  = exp_req ? (k == 1 + v.rdy_wait)
                                 : (is_ld && !v.err && k > 1 + v.rdy_wait && k < done_k);
            // rvalid noise during un-ready REQ cycles must be ignored
            mem_rvalid = rd_cyc || (exp_req && (k != 1 + v.rdy_wait));
            mem_rdata  = rd_cyc ? v.rdata : ~v.rdata;
            @(negedge clk);
            chk("stall",    {31'd0, stall},    {31'd0, (k < done_k)});
            chk("mem_req",  {31'd0, mem_req},  {31'd0, exp_req});
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, (is_ld && !v.err && k == done_k)});
            chk("lsu_err",  {31'd0, lsu_err},  {31'd0, (v.err && k == done_k)});
            if (exp_req) begin
                chk("mem_addr", mem_addr, v.maddr);
                chk("mem_be",   {28'd0, mem_be}, {28'd0, v.be});
                chk("mem_we",   {31'd0, mem_we}, {31'd0, v.we});
                if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
            end
            if (is_ld && !v.err && k == done_k) begin
                chk("wb_data", wb_data, v.wb);
                chk("wb_rd",   {27'd0, wb_rd}, {27'd0, v.rd});
            end
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        $display("op %0d: we=%0b ld=%0b size=%03b addr=%h err=%0b cycles=%0d bad=%0d",
                 idx, v.we, v.ld, v.size, v.addr, v.err, done_k, bad);
    endtask

    int   stage, whs, rhs, wbs, st_done_cyc, wb_cyc;
    logic advance, rv_pend;

    initial begin
        //               we ld size    addr          wdata         rdata         rd  rw vw err be       maddr         mwdata        wb
        vecs[0]  = mk(0, 1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 5,  0, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80);
        vecs[1]  = mk(0, 1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 6,  0, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080);
        vecs[2]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        0,  0, 0, 0, 4'b1100, 32'h0000_0100, 32'hABCD_ABCD, 32'h0);
        vecs[3]  = mk(0, 1, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         4,  0, 0, 1, 4'b0000, 32'h0,         32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 3'b001, 32'h0000_0003, 32'h0,        32'h0,         4,  0, 0, 1, 4'b0000, 32'h0,         32'h0,        32'h0);
        vecs[5]  = mk(1, 0, 3'b100, 32'h0000_0100, 32'h55,       32'h0,         0,  0, 0, 1, 4'b0000, 32'h0,         32'h0,        32'h0);
        vecs[6]  = mk(0, 1, 3'b010, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 31, 3, 2, 0, 4'b1111, 32'h0000_0200, 32'h0,        32'hCAFE_F00D);
        vecs[7]  = mk(1, 0, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'h0,        0,  2, 0, 0, 4'b0010, 32'h0000_0200, 32'h7878_7878, 32'h0);
        vecs[8]  = mk(1, 0, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0,        0,  0, 0, 0, 4'b1111, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0);
        vecs[9]  = mk(0, 1, 3'b001, 32'h0000_0002, 32'h0,        32'h80FF_1234, 1,  0, 0, 0, 4'b1100, 32'h0000_0000, 32'h0,        32'hFFFF_80FF);
        vecs[10] = mk(0, 1, 3'b101, 32'h0000_0000, 32'h0,        32'h80FF_9234, 2,  0, 1, 0, 4'b0011, 32'h0000_0000, 32'h0,        32'h0000_9234);
        vecs[11] = mk(0, 1, 3'b000, 32'h0000_0001, 32'h0,        32'h80FF_1234, 3,  0, 0, 0, 4'b0010, 32'h0000_0000, 32'h0,        32'h0000_0012);
        vecs[12] = mk(0, 1, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         8,  0, 0, 1, 4'b0000, 32'h0,         32'h0,        32'h0);
        vecs[13] = mk(1, 0, 3'b010, 32'h0000_0202, 32'h1,        32'h0,         0,  0, 0, 1, 4'b0000, 32'h0,         32'h0,        32'h0);

        rst_n = 1'b0; req_valid = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; memsize = 3'b000;
        addr = 32'h0; wdata = 32'h0; rd = 5'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1; rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_op(vecs[i], i);

        // ---- reset asserted while waiting for read data ----
        @(posedge clk); #1;
        req_valid = 1'b1; memwrite = 1'b0; memtoreg = 1'b1; memsize = 3'b010;
        addr = 32'h0000_0300; rd = 5'd7;
        @(posedge clk); #1; req_valid = 1'b0; memtoreg = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_wait");
        @(posedge clk); #1; rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("post_rst_wbv",   {31'd0, wb_valid}, 32'd0);
        chk("post_rst_stall", {31'd0, stall},    32'd0);
        chk("post_rst_req",   {31'd0, mem_req},  32'd0);
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_wbv2",  {31'd0, wb_valid}, 32'd0);
        $display("op reset_in_wait: bad=%0d", bad);
        run_op(vecs[0], 100);

        // ---- back-to-back store then load, req_valid held high ----
        stage = 0; whs = 0; rhs = 0; wbs = 0; st_done_cyc = -1; wb_cyc = -1;
        advance = 1'b0; rv_pend = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; memwrite = 1'b1; memtoreg = 1'b0; memsize = 3'b010;
        addr = 32'h0000_0040; wdata = 32'h1122_3344; rd = 5'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5566_7788;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                mem_ready  = mem_req;
                mem_rvalid = rv_pend;
                rv_pend    = 1'b0;
                if (advance) begin
                    advance = 1'b0;
                    stage++;
                    if (stage == 1) begin
                        memwrite = 1'b0; memtoreg = 1'b1; rd = 5'd9;
                    end else begin
                        req_valid = 1'b0; memtoreg = 1'b0;
                    end
                end
            end
            @(negedge clk);
            if (mem_req && mem_ready) begin
                if (mem_we) whs++;
                else begin rhs++; rv_pend = 1'b1; end
            end
            if (wb_valid) begin
                wbs++; wb_cyc = c;
                chk("b2b_wb_data", wb_data, 32'h5566_7788);
                chk("b2b_wb_rd", {27'd0, wb_rd}, 32'd9);
            end
            if (req_valid && !stall) begin
                advance = 1'b1;
                if (stage == 0) st_done_cyc = c;
            end
        end
        chk("b2b_writes",    whs, 32'd1);
        chk("b2b_reads",     rhs, 32'd1);
        chk("b2b_wbs",       wbs, 32'd1);
        chk("b2b_st_done",   st_done_cyc, 32'd2);
        chk("b2b_wb_cycle",  wb_cyc, 32'd6);
        chk("b2b_stage",     stage, 32'd2);
        $display("op back_to_back: writes=%0d reads=%0d wbs=%0d bad=%0d", whs, rhs, wbs, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting in the execute stage, directly downstream of the main decoder. It consumes the decoder's `memwrite`, `memtoreg` and `memsize` controls, together with the ALU address and the rs2 store data. It runs a valid/ready transaction on the data-memory port and stalls the pipeline until the access completes. For loads it returns a sign- or zero-extended result, tagged with its destination register, to writeback. Misaligned accesses and illegal size encodings are rejected without touching memory.

## Interface
- ADDR_W, 32, address width (data width is fixed at 32)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds a decoded instruction (qualifies memwrite/memtoreg)
- memwrite  in  1  store
- memtoreg  in  1  load
- memsize  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  effective address (ALU result)
- wdata  in  32  store data (rs2)
- rd  in  5  load destination register
- stall  out  1  freeze PC/IF/ID/EX
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ready  in  1  memory accepts request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  load result valid (1 cycle)
- wb_rd  out  5  load destination
- wb_data  out  32  extended load result
- lsu_err  out  1  misaligned/illegal access (1 cycle)

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Accept condition: IDLE && req_valid && (memwrite | memtoreg). The op, extracted offset addr[1:0], memsize and rd are latched on acceptance.
- Legal: memsize in {000,001,010} for stores; {000,001,010,100,101} for loads.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Illegal or misaligned op: IDLE -> DONE with lsu_err=1. No mem_req, no wb_valid.
- Legal op: IDLE -> REQ.
- REQ: mem_req=1, outputs held stable. On mem_ready: a store goes to DONE; a load goes to WAIT.
- WAIT: on mem_rvalid, extract and extend the data, register wb_data/wb_rd, and go to DONE.
- DONE: lasts exactly one cycle. wb_valid=1 for a completed load. stall=0 and req_valid is ignored (the pipeline advances the op). Next state is IDLE.
- stall = accept condition (combinational) | REQ | WAIT. It is 0 in DONE and in a non-accepting IDLE.
- Byte enables and store data:
  - SB: be = 0001<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, mem_wdata = wdata.
- Loads: mem_we=0, be as for the same size. The lane is selected as mem_rdata >> (8*offset), then:
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W is passed through.
- mem_rvalid in any state other than WAIT is ignored. mem_ready outside REQ is ignored.
- Reset (async, any state): state=IDLE. stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_rd, wb_data and lsu_err all go to 0. An in-flight access is abandoned and no writeback is produced.

## Timing
- Acceptance in cycle T (stall=1); mem_req rises at T+1 from registered outputs.
- Store with zero wait: mem_ready at T+1, DONE at T+2, stall=0 at T+2. Total 3 cycles including DONE.
- Load with zero wait: mem_ready at T+1, mem_rvalid at T+2 (earliest), DONE/wb_valid at T+3.
- Each cycle of mem_ready or mem_rvalid low adds exactly one cycle of stall.
- Error path: lsu_err and DONE at T+1, with stall=0 at T+1.
- mem_addr, mem_be, mem_we and mem_wdata do not change while mem_req=1 and mem_ready=0.
- Back-to-back memory ops: the second is accepted no earlier than the cycle after DONE.

## Test plan
- LB at addr 0x103, mem_rdata 0x80FF1234, ready and rvalid zero-wait -> mem_addr 0x100, be 1000. wb_data 0xFFFFFF80 with wb_valid at T+3. The same with LBU -> 0x00000080.
- SH at addr 0x102, wdata 0x0000ABCD -> mem_we=1, be 1100, mem_wdata 0xABCDABCD, mem_addr 0x100. No wb_valid, stall low at T+2.
- LW at 0x101 and LH at 0x003 -> lsu_err pulse at T+1, mem_req never asserted, stall high only in cycle T. Store with memsize 100 -> lsu_err.
- LW at 0x200 with mem_ready held low 3 cycles and rvalid 2 cycles later -> address and controls held stable; stall high for exactly the extra 5 cycles; wb_data = mem_rdata.
- rst_n pulled low in WAIT, then rvalid arrives -> all outputs 0. No wb_valid after release; next op accepted normally.
- Store then load back-to-back with req_valid held high -> exactly one memory transaction per op, none duplicated across the DONE cycle.
